// File: rtl/nibble_entry_pkg.sv
// Shared types and constants for the nibble entry controller.
package nibble_entry_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        CLEAR    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DIGIT_W           = 4;

endpackage

// File: rtl/nibble_entry_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability-count debouncer and rise pulse.
module btn_debounce
    import nibble_entry_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]       sync_reg;
    logic [1:0]       vld_reg;
    logic             armed_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    // armed_reg only sets once a genuinely synchronized low has been seen, so a
    // button held through reset must be released before it can raise an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            vld_reg   <= '0;
            armed_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            vld_reg  <= {vld_reg[0], 1'b1};
            rise_reg <= 1'b0;
            if (vld_reg[1] && !sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
            if (sync_reg[1] != level_reg) begin
                if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                    level_reg <= sync_reg[1];
                    rise_reg  <= sync_reg[1] & armed_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/nibble_entry_ctrl.sv
// Loads the switch nibble into an N-digit display buffer under LOAD/NEXT/CLEAR control.
// Optional macro AUTO_ADVANCE_EN: each write also advances the cursor.
module nibble_entry_ctrl
    import nibble_entry_pkg::*;
#(
    parameter int  NUM_DIGITS = 8,
    parameter int  DB_CYCLES  = DB_CYCLES_DEFAULT,
    localparam int CURSOR_W   = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W-1:0]            nibble,
    input  logic                          btn_load,
    input  logic                          btn_next,
    input  logic                          btn_clear,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [CURSOR_W-1:0]           cursor,
    output logic                          wr_pulse,
    output logic                          busy
);

    localparam int BTN_LOAD  = 0;
    localparam int BTN_NEXT  = 1;
    localparam int BTN_CLEAR = 2;

    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;

    assign btn_raw = {btn_clear, btn_next, btn_load};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk   (clk),
                .rst_n (rst_n),
                .btn   (btn_raw[gi]),
                .level (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    logic load_evt, next_evt, clear_evt;
    assign load_evt  = btn_rise[BTN_LOAD];
    assign next_evt  = btn_rise[BTN_NEXT];
    assign clear_evt = btn_rise[BTN_CLEAR];

    state_t              state_reg, state_next;
    logic [CURSOR_W-1:0] cursor_reg, cursor_next, cursor_inc;
    logic                wr_pulse_reg;
    logic                busy_reg;
    logic [DIGIT_W-1:0]  digit_reg [NUM_DIGITS];

    assign cursor_inc = (cursor_reg == CURSOR_W'(NUM_DIGITS - 1)) ? '0
                                                                   : cursor_reg + CURSOR_W'(1);

    always_comb begin
        state_next  = state_reg;
        cursor_next = cursor_reg;
        case (state_reg)
            IDLE: begin
                if (clear_evt) begin
                    state_next = CLEAR;
                end else if (load_evt) begin
                    state_next = WRITE;
                end else if (next_evt) begin
                    cursor_next = cursor_inc;
                end
            end
            WRITE: begin
                state_next = WAIT_REL;
`ifdef AUTO_ADVANCE_EN
                cursor_next = cursor_inc;
`endif
            end
            CLEAR: begin
                state_next  = WAIT_REL;
                cursor_next = '0;
            end
            WAIT_REL: begin
                if (clear_evt) begin
                    state_next = CLEAR;
                end else if (btn_level == 3'b000) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // wr_pulse and busy are registered from state_next so they line up with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cursor_reg   <= '0;
            wr_pulse_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cursor_reg   <= cursor_next;
            wr_pulse_reg <= (state_next == WRITE);
            busy_reg     <= (state_next != IDLE);
        end
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    digit_reg[gi] <= '0;
                end else if (state_reg == CLEAR) begin
                    digit_reg[gi] <= '0;
                end else if (state_reg == WRITE && cursor_reg == CURSOR_W'(gi)) begin
                    digit_reg[gi] <= nibble;
                end
            end
            assign digits[gi*DIGIT_W +: DIGIT_W] = digit_reg[gi];
        end
    endgenerate

    assign cursor   = cursor_reg;
    assign wr_pulse = wr_pulse_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_nibble_entry_ctrl.sv
// Directed self-checking bench for nibble_entry_ctrl (NUM_DIGITS=8, DB_CYCLES=4).
module tb_nibble_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  nibble;
    logic        btn_load, btn_next, btn_clear;
    logic [31:0] digits;
    logic [2:0]  cursor;
    logic        wr_pulse;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt;

    nibble_entry_ctrl #(.NUM_DIGITS(8), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nibble    (nibble),
        .btn_load  (btn_load),
        .btn_next  (btn_next),
        .btn_clear (btn_clear),
        .digits    (digits),
        .cursor    (cursor),
        .wr_pulse  (wr_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_load  = v;
            1: btn_next  = v;
            default: btn_clear = v;
        endcase
    endtask

    // Clean press held for 'hold' cycles, then released for 'rel' cycles.
    task automatic press(input int which, input int hold, input int rel, output int wr);
        wr = 0;
        set_btn(which, 1'b1);
        repeat (hold) begin
            tick(1);
            if (wr_pulse) wr++;
        end
        set_btn(which, 1'b0);
        repeat (rel) begin
            tick(1);
            if (wr_pulse) wr++;
        end
        $display("press btn=%0d nibble=%h -> wr=%0d digits=%h cursor=%0d busy=%b",
                 which, nibble, wr, digits, cursor, busy);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; nibble = 4'h0;
        btn_load = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
        tick(3);
        chk("rst_digits", digits, 32'h0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_wr", 32'(wr_pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // First LOAD
        nibble = 4'hA;
        press(0, 20, 20, wr_cnt);
        chk("load1_wr", 32'(wr_cnt), 32'd1);
        chk("load1_digits", digits, 32'h0000000A);
`ifdef AUTO_ADVANCE_EN
        chk("load1_cursor", 32'(cursor), 32'd1);
`else
        chk("load1_cursor", 32'(cursor), 32'd0);
`endif
        chk("load1_busy", 32'(busy), 32'd0);

        // NEXT x9 with wrap, then LOAD 5
        for (int i = 0; i < 9; i++) press(1, 20, 20, wr_cnt);
`ifdef AUTO_ADVANCE_EN
        chk("next9_cursor", 32'(cursor), 32'd2);
`else
        chk("next9_cursor", 32'(cursor), 32'd1);
`endif
        nibble = 4'h5;
        press(0, 20, 20, wr_cnt);
        chk("load2_wr", 32'(wr_cnt), 32'd1);
`ifdef AUTO_ADVANCE_EN
        chk("load2_digits", digits, 32'h0000050A);
        chk("load2_cursor", 32'(cursor), 32'd3);
`else
        chk("load2_digits", digits, 32'h0000005A);
        chk("load2_cursor", 32'(cursor), 32'd1);
`endif

        // Bouncy LOAD: 3-cycle pulses for 20 cycles, then stable high
        nibble = 4'hC;
        wr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            btn_load = ((i % 6) < 3);
            tick(1);
            if (wr_pulse) wr_cnt++;
        end
        btn_load = 1'b1;
        repeat (20) begin
            tick(1);
            if (wr_pulse) wr_cnt++;
        end
        chk("bounce_busy_held", 32'(busy), 32'd1);
        btn_load = 1'b0;
        repeat (20) begin
            tick(1);
            if (wr_pulse) wr_cnt++;
        end
        $display("bounce load nibble=%h -> wr=%0d digits=%h", nibble, wr_cnt, digits);
        chk("bounce_wr", 32'(wr_cnt), 32'd1);
        chk("bounce_busy_rel", 32'(busy), 32'd0);
`ifdef AUTO_ADVANCE_EN
        chk("bounce_digits", digits, 32'h0000C50A);
`else
        chk("bounce_digits", digits, 32'h000000CA);
`endif

        // CLEAR, then fill digits 0..7 with 1..8
        press(2, 20, 20, wr_cnt);
        chk("clr1_digits", digits, 32'h0);
        chk("clr1_cursor", 32'(cursor), 32'd0);
        for (int i = 0; i < 8; i++) begin
            nibble = 4'(i + 1);
            press(0, 20, 20, wr_cnt);
`ifndef AUTO_ADVANCE_EN
            press(1, 20, 20, wr_cnt);
`endif
        end
        chk("fill_digits", digits, 32'h87654321);
        chk("fill_cursor", 32'(cursor), 32'd0);
        press(1, 20, 20, wr_cnt);
        chk("pre_clr_cursor", 32'(cursor), 32'd1);

        // CLEAR timing: digits zero one cycle after the CLEAR state
        btn_clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            tick(1);
            if (busy) seen = 1;
        end
        chk("clr2_busy_seen", 32'(seen), 32'd1);
        chk("clr2_in_state_digits", digits, 32'h87654321);
        tick(1);
        chk("clr2_digits", digits, 32'h0);
        chk("clr2_cursor", 32'(cursor), 32'd0);
        tick(19);
        btn_clear = 1'b0;
        tick(20);
        $display("clear -> digits=%h cursor=%0d busy=%b", digits, cursor, busy);

        // LOAD and NEXT on the same cycle: write only
        nibble = 4'h7;
        btn_load = 1'b1; btn_next = 1'b1;
        wr_cnt = 0;
        repeat (20) begin
            tick(1);
            if (wr_pulse) wr_cnt++;
        end
        btn_load = 1'b0; btn_next = 1'b0;
        tick(20);
        $display("load+next nibble=%h -> wr=%0d digits=%h cursor=%0d", nibble, wr_cnt, digits, cursor);
        chk("ln_wr", 32'(wr_cnt), 32'd1);
        chk("ln_digits", digits, 32'h00000007);
`ifdef AUTO_ADVANCE_EN
        chk("ln_cursor", 32'(cursor), 32'd1);
`else
        chk("ln_cursor", 32'(cursor), 32'd0);
`endif

        // LOAD held, CLEAR pressed from WAIT_REL
        nibble = 4'h9;
        btn_load = 1'b1;
        tick(15);
`ifdef AUTO_ADVANCE_EN
        chk("lh_digits", digits, 32'h00000097);
`else
        chk("lh_digits", digits, 32'h00000009);
`endif
        btn_clear = 1'b1;
        tick(15);
        chk("lh_clr_digits", digits, 32'h0);
        chk("lh_clr_cursor", 32'(cursor), 32'd0);
        chk("lh_clr_busy", 32'(busy), 32'd1);
        btn_load = 1'b0; btn_clear = 1'b0;
        tick(20);
        chk("lh_rel_busy", 32'(busy), 32'd0);
        $display("load-held clear -> digits=%h cursor=%0d busy=%b", digits, cursor, busy);

        // Reset in WAIT_REL with LOAD held
        nibble = 4'h3;
        btn_load = 1'b1;
        tick(15);
        chk("wr_before_rst_busy", 32'(busy), 32'd1);
        chk("wr_before_rst_digits", digits, 32'h00000003);
        rst_n = 1'b0;
        #2;
        chk("async_rst_digits", digits, 32'h0);
        chk("async_rst_cursor", 32'(cursor), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_wr", 32'(wr_pulse), 32'd0);
        tick(2);
        rst_n = 1'b1;
        wr_cnt = 0;
        repeat (30) begin
            tick(1);
            if (wr_pulse) wr_cnt++;
        end
        chk("held_thru_rst_wr", 32'(wr_cnt), 32'd0);
        chk("held_thru_rst_digits", digits, 32'h0);
        btn_load = 1'b0;
        tick(20);
        nibble = 4'h6;
        press(0, 20, 20, wr_cnt);
        chk("repress_wr", 32'(wr_cnt), 32'd1);
        chk("repress_digits", digits, 32'h00000006);
`ifdef AUTO_ADVANCE_EN
        chk("repress_cursor", 32'(cursor), 32'd1);
`else
        chk("repress_cursor", 32'(cursor), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
